countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter that complements the up-stepping `COUNTER`. `COUNTER` advances an address/timestamp by a fixed step of 0x0200. This block is loaded with a value, decrements it by the same step every enabled cycle, and signals completion when it reaches zero. It sits beside `COUNTER` in the timing path as the consumer side: it measures out an interval in the same step units that `COUNTER` produces. The count is held in a registered state machine with a start/busy/done handshake.

## Interface

Parameters:
- `WIDTH`, 16: counter width in bits.
- `STEP`, 16'h0200: decrement applied per enabled cycle; must be nonzero and less than 2^WIDTH.
- `RESET_VALUE`, 16'h0300: value of `count_now` after reset.

Ports:
- `CLK`  input  1  system clock; all state changes on the rising edge.
- `RESET`  input  1  synchronous, active-low reset. Sampled on the `CLK` rising edge; `RESET`=0 forces the reset state.
- `ENABLE`  input  1  count enable; 0 freezes the counter in RUN.
- `LOAD`  input  1  start strobe; loads `load_value` and enters RUN.
- `load_value`  input  WIDTH  initial count.
- `count_now`  output  WIDTH  current registered count.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse, high in the cycle after the count reaches zero.

## Operation

- Two states: IDLE and RUN. All outputs are registered.
- Reset values: `count_now`=`RESET_VALUE`, `busy`=0, `done`=0, state IDLE, reload register=0.
- Priority on each edge, highest first: `RESET`=0, then `LOAD`=1, then the RUN decrement.
- `LOAD`=1 in any state:
  - `count_now` ← `load_value`, reload register ← `load_value`.
  - State → RUN, `busy` ← 1, `done` ← 0.
  - A `LOAD` during RUN restarts the count. No `done` is produced for the aborted count.
- RUN with `ENABLE`=1:
  - If `count_now` > `STEP`: `count_now` ← `count_now` − `STEP`.
  - If `count_now` ≤ `STEP`: `count_now` ← 0, `done` ← 1, and the terminal action applies (see Configuration).
  - Subtraction is unsigned, WIDTH bits. The result saturates at 0 and never wraps.
- RUN with `ENABLE`=0: all state holds and `done` ← 0.
- IDLE: `count_now` holds its last value. `ENABLE` is ignored.
- `load_value`=0: enters RUN with count 0. The first enabled cycle produces `done` and the terminal action.

## Timing

- Load latency: `count_now` shows `load_value` one cycle after `LOAD` is sampled.
- For a loaded value V with `ENABLE` held at 1, `done` asserts ceil(V/STEP) enabled cycles after the load edge. The minimum is one cycle after the load edge for V ≤ STEP, including V=0.
- `done` is high for exactly one cycle, coincident with `count_now`=0 at the terminal edge.
- `busy` falls on the same edge that raises `done` (non-reload build).
- If `LOAD` and the terminal decrement fall on the same edge, the load wins: `done`=0 and the new count is loaded.
- If `RESET` is asserted mid-count, the next edge gives the reset values and no `done`.

## Configuration

- `COUNTDOWN_AUTORELOAD_EN` undefined:
  - The terminal edge sends the state to IDLE with `busy` ← 0.
  - `count_now` stays 0 until the next `LOAD`.
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - The terminal edge pulses `done` and sets `count_now` ← reload register instead of 0.
  - The state stays RUN and `busy` stays 1.
  - The block then produces a periodic `done` every ceil(V/STEP) enabled cycles until `LOAD` or `RESET`.
  - A reload value of 0 gives `done` on every enabled cycle.

## Test plan

- Reset: hold `RESET`=0 for 2 cycles with `LOAD`=1 → `count_now`=0x0300, `busy`=0, `done`=0, and `LOAD` is ignored.
- Exact multiple: load 0x0A00 with `ENABLE`=1 → `count_now` is 0x0A00, 0x0800, 0x0600, 0x0400, 0x0200, 0x0000. `done` is high only in the cycle showing 0x0000, and `busy` drops on the same edge.
- Non-multiple plus pause: load 0x0250, then drop `ENABLE` for 3 cycles after the first decrement → the count reads 0x0050 for 3 cycles, then 0x0000 with `done`=1. The result never wraps.
- Restart and collision: load 0x0400, then assert `LOAD` with 0x0600 on the edge where the count would reach 0 → no `done`, `count_now`=0x0600, `busy`=1.
- Mid-run reset: load 0x1000, then pull `RESET` low after 2 decrements → `count_now`=0x0300, `busy`=0, and no `done` afterwards.
- With `COUNTDOWN_AUTORELOAD_EN`: load 0x0400 with `ENABLE`=1 → `done` every 2 cycles and the count sequence 0x0200, 0x0000→0x0400, repeating, with `busy` held at 1.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Handshake bundle for countdown_timer: start strobe, enable and load value in; count, busy and done out.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             ENABLE;
  logic             LOAD;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_now;
  logic             busy;
  logic             done;

  modport master (
    output ENABLE, LOAD, load_value,
    input  count_now, busy, done
  );

  modport slave (
    input  ENABLE, LOAD, load_value,
    output count_now, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter stepping by STEP per enabled cycle, with saturating terminal and one-cycle done pulse.
// Optional feature: define COUNTDOWN_AUTORELOAD_EN to reload the loaded value at terminal count and keep running.
module countdown_timer #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] STEP        = 16'h0200,
  parameter logic [WIDTH-1:0] RESET_VALUE = 16'h0300
) (
  input  logic              CLK,
  input  logic              RESET,
  countdown_timer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] count_d;
  logic             terminal_d;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  // Terminal when the next step would reach or pass zero; never wraps.
  assign terminal_d = (count_q <= STEP);
  assign count_d    = count_q - STEP;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      count_q <= RESET_VALUE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else if (bus.LOAD) begin
      state_q <= RUN;
      count_q <= bus.load_value;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= bus.load_value;
`endif
    end else if (state_q == RUN && bus.ENABLE) begin
      if (terminal_d) begin
        done_q <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        count_q <= reload_q;
`else
        count_q <= '0;
        state_q <= IDLE;
        busy_q  <= 1'b0;
`endif
      end else begin
        count_q <= count_d;
        done_q  <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.count_now = count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; expectations adapt to COUNTDOWN_AUTORELOAD_EN.
module tb_countdown_timer;
  localparam int unsigned W = 16;
`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(
    .WIDTH      (W),
    .STEP       (16'h0200),
    .RESET_VALUE(16'h0300)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.LOAD = 1'b1;
    bus.load_value = 16'h1234;
    bus.ENABLE = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.count_now !== 16'h0300) begin errors++; $display("FAIL reset_count: got %h want 0300", bus.count_now); end
    vectors++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst_n = 1'b1;
    bus.LOAD = 1'b0;
    tick();
    vectors++;
    if (bus.count_now !== 16'h0300 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_enable: count %h busy %b want 0300 0", bus.count_now, bus.busy);
    end
  endtask

  task automatic test_exact_multiple;
    logic [15:0] ec [6];
    logic        ed [6];
    logic        eb [6];
    ec = '{16'h0A00, 16'h0800, 16'h0600, 16'h0400, 16'h0200, (AR ? 16'h0A00 : 16'h0000)};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, AR};
    bus.ENABLE = 1'b1;
    bus.LOAD = 1'b1;
    bus.load_value = 16'h0A00;
    tick();
    bus.LOAD = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      vectors++;
      if (bus.count_now !== ec[i] || bus.done !== ed[i] || bus.busy !== eb[i]) begin
        errors++;
        $display("FAIL exact_step%0d: count %h done %b busy %b want %h %b %b",
                 i, bus.count_now, bus.done, bus.busy, ec[i], ed[i], eb[i]);
      end
    end
    tick();
    vectors++;
    if (bus.count_now !== (AR ? 16'h0800 : 16'h0000) || bus.done !== 1'b0 || bus.busy !== AR) begin
      errors++;
      $display("FAIL exact_after: count %h done %b busy %b want %h 0 %b",
               bus.count_now, bus.done, bus.busy, (AR ? 16'h0800 : 16'h0000), AR);
    end
  endtask

  task automatic test_pause;
    bus.ENABLE = 1'b1;
    bus.LOAD = 1'b1;
    bus.load_value = 16'h0250;
    tick();
    bus.LOAD = 1'b0;
    vectors++;
    if (bus.count_now !== 16'h0250) begin errors++; $display("FAIL pause_load: got %h want 0250", bus.count_now); end
    tick();
    bus.ENABLE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      vectors++;
      if (bus.count_now !== 16'h0050 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL pause_hold%0d: count %h done %b busy %b want 0050 0 1", i, bus.count_now, bus.done, bus.busy);
      end
    end
    bus.ENABLE = 1'b1;
    tick();
    vectors++;
    if (bus.count_now !== (AR ? 16'h0250 : 16'h0000) || bus.done !== 1'b1 || bus.busy !== AR) begin
      errors++;
      $display("FAIL pause_terminal: count %h done %b busy %b want %h 1 %b",
               bus.count_now, bus.done, bus.busy, (AR ? 16'h0250 : 16'h0000), AR);
    end
  endtask

  task automatic test_back_to_back;
    bus.ENABLE = 1'b1;
    bus.LOAD = 1'b1;
    bus.load_value = 16'h0400;
    tick();
    bus.LOAD = 1'b0;
    tick();
    vectors++;
    if (bus.count_now !== 16'h0200) begin errors++; $display("FAIL restart_pre: got %h want 0200", bus.count_now); end
    bus.LOAD = 1'b1;
    bus.load_value = 16'h0600;
    tick();
    bus.LOAD = 1'b0;
    vectors++;
    if (bus.count_now !== 16'h0600 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_collision: count %h done %b busy %b want 0600 0 1", bus.count_now, bus.done, bus.busy);
    end
    tick();
    vectors++;
    if (bus.count_now !== 16'h0400 || bus.done !== 1'b0) begin
      errors++; $display("FAIL restart_continue: count %h done %b want 0400 0", bus.count_now, bus.done);
    end
  endtask

  task automatic test_load_zero;
    bus.ENABLE = 1'b1;
    bus.LOAD = 1'b1;
    bus.load_value = 16'h0000;
    tick();
    bus.LOAD = 1'b0;
    vectors++;
    if (bus.count_now !== 16'h0000 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL zero_load: count %h busy %b done %b want 0000 1 0", bus.count_now, bus.busy, bus.done);
    end
    tick();
    vectors++;
    if (bus.count_now !== 16'h0000 || bus.done !== 1'b1 || bus.busy !== AR) begin
      errors++; $display("FAIL zero_terminal: count %h done %b busy %b want 0000 1 %b", bus.count_now, bus.done, bus.busy, AR);
    end
    tick();
    vectors++;
    if (bus.done !== AR) begin errors++; $display("FAIL zero_next: done %b want %b", bus.done, AR); end
  endtask

  task automatic test_midrun_reset;
    bus.ENABLE = 1'b1;
    bus.LOAD = 1'b1;
    bus.load_value = 16'h1000;
    tick();
    bus.LOAD = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.count_now !== 16'h0C00) begin errors++; $display("FAIL midrun_count: got %h want 0C00", bus.count_now); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (bus.count_now !== 16'h0300 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: count %h busy %b done %b want 0300 0 0", bus.count_now, bus.busy, bus.done);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (bus.done !== 1'b0 || bus.count_now !== 16'h0300 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL midrun_quiet%0d: count %h busy %b done %b want 0300 0 0", i, bus.count_now, bus.busy, bus.done);
      end
    end
  endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
  task automatic test_autoreload;
    logic [15:0] ec [6];
    logic        ed [6];
    ec = '{16'h0400, 16'h0200, 16'h0400, 16'h0200, 16'h0400, 16'h0200};
    ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus.ENABLE = 1'b1;
    bus.LOAD = 1'b1;
    bus.load_value = 16'h0400;
    tick();
    bus.LOAD = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      vectors++;
      if (bus.count_now !== ec[i] || bus.done !== ed[i] || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL autoreload_step%0d: count %h done %b busy %b want %h %b 1",
                 i, bus.count_now, bus.done, bus.busy, ec[i], ed[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.ENABLE = 1'b0;
    bus.LOAD = 1'b0;
    bus.load_value = '0;
    rst_n = 1'b0;
    test_reset();
    test_exact_multiple();
    test_pause();
    test_back_to_back();
    test_load_zero();
    test_midrun_reset();
`ifdef COUNTDOWN_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
